// File: rtl/selevy_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port, synchronous-read RAM.
// Every output is registered; one access is in flight at a time (IDLE -> GRANT [-> RDWAIT]).
module selevy_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              m0_gnt_q, m0_gnt_d;
  logic              m1_gnt_q, m1_gnt_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              busy_q, busy_d;

  // On a tie the requester that did not win last time goes next.
  function automatic logic pick_winner(input logic req0, input logic req1, input logic last);
    if (req0 && req1) begin
      return ~last;
    end
    return req1;
  endfunction

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          sel_d    = pick_winner(m0_req, m1_req, last_q);
          last_d   = sel_d;
          ram_en_d = 1'b1;
          if (sel_d) begin
            ram_we_d    = m1_we;
            ram_addr_d  = m1_addr;
            ram_wdata_d = m1_wdata;
            m1_gnt_d    = 1'b1;
          end else begin
            ram_we_d    = m0_we;
            ram_addr_d  = m0_addr;
            ram_wdata_d = m0_wdata;
            m0_gnt_d    = 1'b1;
          end
          state_d = GRANT;
        end
      end
      GRANT: begin
        // The RAM acts on the strobe at this edge; reads return data one cycle later.
        state_d = ram_we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        if (sel_q) begin
          m1_rdata_d  = ram_rdata;
          m1_rvalid_d = 1'b1;
        end else begin
          m0_rdata_d  = ram_rdata;
          m0_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule
